fp_mul_result_queue: RTL and testbench

//   Downstream stage of the FP32 multiplier. Accepts {fp_result, result_str} over a valid/ready

---
 rtl/fp_mul_result_queue_if.sv | 41 ++++
 rtl/fp_mul_result_queue.sv | 131 +++++++++++++
 tb/tb_fp_mul_result_queue.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/fp_mul_result_queue_if.sv
// Result-status encoding shared with the FP32 multiplier, and the valid/ready
// bundle that carries results into and out of the result queue.

package float_type;
    // Status word produced by the multiplier alongside each fp_result.
    typedef enum logic [2:0] {
        VALID             = 3'd0,
        OVERFLOW          = 3'd1,
        UNDERFLOW         = 3'd2,
        normalized        = 3'd3,
        denormalized      = 3'd4,
        positive_infinity = 3'd5,
        negative_infinity = 3'd6,
        NaN               = 3'd7
    } type_of_float;
endpackage

interface fp_mul_result_queue_if;
    import float_type::*;

    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_result;
    type_of_float in_status;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_result;
    type_of_float out_status;

    // Queue side: consumes the upstream stream, produces the downstream one.
    modport slave (
        input  in_valid, in_result, in_status, out_ready,
        output in_ready, out_valid, out_result, out_status
    );

    // Producer/consumer side facing the queue.
    modport master (
        output in_valid, in_result, in_status, out_ready,
        input  in_ready, out_valid, out_result, out_status
    );
endinterface

// File: rtl/fp_mul_result_queue.sv
// Result queue behind the FP32 multiplier: replaces exception results with
// their IEEE-style encodings, buffers them in a first-word-fall-through FIFO,
// and keeps sticky exception flags plus a saturating result counter.

module fp_mul_result_queue
    import float_type::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    fp_mul_result_queue_if.slave     bus,
    input  logic                     flags_clear,
    output logic [3:0]               sticky_flags,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         result_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_LEVEL = (PTR_W + 1)'(DEPTH);

    // Flag bit positions: {invalid, overflow, underflow, infinity}
    localparam logic [3:0] EV_INVALID   = 4'b1000;
    localparam logic [3:0] EV_OVERFLOW  = 4'b0100;
    localparam logic [3:0] EV_UNDERFLOW = 4'b0010;
    localparam logic [3:0] EV_INFINITY  = 4'b0001;

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   level_reg;
    logic [3:0]       sticky_reg;
    logic [3:0]       sticky_next;
    logic [3:0]       event_flags;
    logic [CNT_W-1:0] cnt_reg;
    logic [31:0]      subst_result;
    logic             not_full;
    logic             not_empty;
    logic             push;
    logic             pop;

    logic [31:0]      result_mem [DEPTH];
    type_of_float     status_mem [DEPTH];

    // Handshake status comes only from the registered level, so in_ready
    // never depends combinationally on out_ready.
    assign not_full  = (level_reg != FULL_LEVEL);
    assign not_empty = (level_reg != '0);
    assign push      = bus.in_valid && not_full;
    assign pop       = not_empty && bus.out_ready;

    assign bus.in_ready   = not_full;
    assign bus.out_valid  = not_empty;
    assign bus.out_result = result_mem[rd_ptr_reg];
    assign bus.out_status = status_mem[rd_ptr_reg];

    assign sticky_flags = sticky_reg;
    assign level        = level_reg;
    assign result_cnt   = cnt_reg;

    // Map the incoming status to its substituted encoding and flag events.
    always_comb begin
        subst_result = bus.in_result;
        event_flags  = 4'b0000;
        case (bus.in_status)
            OVERFLOW: begin
                subst_result = {bus.in_result[31], 8'hFF, 23'h0};
                event_flags  = EV_OVERFLOW | EV_INFINITY;
            end
            UNDERFLOW: begin
                subst_result = {bus.in_result[31], 31'h0};
                event_flags  = EV_UNDERFLOW;
            end
            positive_infinity: begin
                subst_result = 32'h7F80_0000;
                event_flags  = EV_INFINITY;
            end
            negative_infinity: begin
                subst_result = 32'hFF80_0000;
                event_flags  = EV_INFINITY;
            end
            NaN: begin
                subst_result = 32'h7FC0_0000;
                event_flags  = EV_INVALID;
            end
            default: begin
                subst_result = bus.in_result;
                event_flags  = 4'b0000;
            end
        endcase
    end

    // Clear first, then OR in whatever the current push reports.
    always_comb begin
        sticky_next = (flags_clear ? 4'b0000 : sticky_reg) | (push ? event_flags : 4'b0000);
    end

    // Storage has no reset; only entries between rd_ptr and wr_ptr are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            result_mem[wr_ptr_reg] <= subst_result;
            status_mem[wr_ptr_reg] <= bus.in_status;
        end
    end

    // Pointers, occupancy, sticky flags and the saturating result counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            sticky_reg <= 4'b0000;
            cnt_reg    <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + (PTR_W + 1)'(1);
                2'b01:   level_reg <= level_reg - (PTR_W + 1)'(1);
                default: level_reg <= level_reg;
            endcase
            sticky_reg <= sticky_next;
            if (push && (cnt_reg != '1)) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_fp_mul_result_queue.sv
// Scoreboard bench for fp_mul_result_queue: a queue-based reference model
// tracks accepted results, flags and count; a monitor checks the DUT every
// cycle and compares each popped entry against the model's head.

module tb_fp_mul_result_queue;
    import float_type::*;

    localparam int DEPTH   = 8;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct {
        logic [31:0]  r;
        type_of_float s;
    } entry_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flags_clear = 1'b0;
    logic [3:0] sticky_flags;
    logic [$clog2(DEPTH):0] level;
    logic [CNT_W-1:0] result_cnt;

    fp_mul_result_queue_if bus ();

    fp_mul_result_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .flags_clear  (flags_clear),
        .sticky_flags (sticky_flags),
        .level        (level),
        .result_cnt   (result_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    entry_t exp_q[$];
    logic [3:0] m_flags = 4'b0000;
    int m_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] model_subst(input logic [31:0] r, input type_of_float s);
        case (s)
            OVERFLOW:          return r[31] ? 32'hFF80_0000 : 32'h7F80_0000;
            UNDERFLOW:         return r[31] ? 32'h8000_0000 : 32'h0000_0000;
            positive_infinity: return 32'h7F80_0000;
            negative_infinity: return 32'hFF80_0000;
            NaN:               return 32'h7FC0_0000;
            default:           return r;
        endcase
    endfunction

    function automatic logic [3:0] model_events(input type_of_float s);
        logic inv, ovf, unf, inf;
        inv = (s == NaN);
        ovf = (s == OVERFLOW);
        unf = (s == UNDERFLOW);
        inf = (s == OVERFLOW) || (s == positive_infinity) || (s == negative_infinity);
        return {inv, ovf, unf, inf};
    endfunction

    // Model update: the queue itself is the FIFO; its size is the level.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            m_flags = 4'b0000;
            m_cnt   = 0;
        end else begin
            automatic bit do_push = bus.in_valid && (exp_q.size() < DEPTH);
            automatic bit do_pop  = bus.out_ready && (exp_q.size() > 0);
            automatic entry_t e;
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) begin
                e.r = model_subst(bus.in_result, bus.in_status);
                e.s = bus.in_status;
                exp_q.push_back(e);
            end
            if (flags_clear) m_flags = 4'b0000;
            if (do_push) m_flags = m_flags | model_events(bus.in_status);
            if (do_push && m_cnt < CNT_MAX) m_cnt++;
        end
    end

    // Monitor: mid-cycle comparison of status outputs and popped entries.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("level", 32'(level), 32'(exp_q.size()));
                check("in_ready", 32'(bus.in_ready), 32'(exp_q.size() < DEPTH));
                check("out_valid", 32'(bus.out_valid), 32'(exp_q.size() > 0));
                check("sticky_flags", 32'(sticky_flags), 32'(m_flags));
                check("result_cnt", 32'(result_cnt), 32'(m_cnt));
                if (bus.out_valid && bus.out_ready && exp_q.size() > 0) begin
                    check("out_result", bus.out_result, exp_q[0].r);
                    check("out_status", 32'(bus.out_status), 32'(exp_q[0].s));
                    $display("pop result=%h status=%s expected=%h/%s",
                             bus.out_result, bus.out_status.name(), exp_q[0].r, exp_q[0].s.name());
                end
            end
        end
    end

    // One cycle of stimulus, applied just after the rising edge.
    task automatic cyc(input logic v, input logic [31:0] r, input type_of_float s,
                       input logic rdy, input logic clr);
        @(posedge clk);
        #1;
        bus.in_valid  = v;
        bus.in_result = r;
        bus.in_status = s;
        bus.out_ready = rdy;
        flags_clear   = clr;
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b0, 32'h0, VALID, rdy, 1'b0);
    endtask

    logic [31:0]  t2_in  [3] = '{32'h8000_0000, 32'h0001_2345, 32'h7F81_2345};
    type_of_float t2_st  [3] = '{OVERFLOW, UNDERFLOW, NaN};
    logic [31:0]  t2_exp [3] = '{32'hFF80_0000, 32'h0000_0000, 32'h7FC0_0000};

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_result = 32'h0;
        bus.in_status = VALID;
        bus.out_ready = 1'b0;
        #11;
        check("reset level", 32'(level), 32'd0);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset in_ready", 32'(bus.in_ready), 32'd1);
        check("reset sticky", 32'(sticky_flags), 32'd0);
        check("reset cnt", 32'(result_cnt), 32'd0);
        #1 rst_n = 1'b1;

        // 1: single push of 3.0
        cyc(1'b1, 32'h4040_0000, VALID, 1'b0, 1'b0);
        idle(1'b0);
        check("t1 out_valid", 32'(bus.out_valid), 32'd1);
        check("t1 out_result", bus.out_result, 32'h4040_0000);
        check("t1 level", 32'(level), 32'd1);
        check("t1 cnt", 32'(result_cnt), 32'd1);
        idle(1'b1);
        idle(1'b0);

        // 2: exception substitutions
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, t2_in[i], t2_st[i], 1'b0, 1'b0);
            idle(1'b0);
            check("t2 out_result", bus.out_result, t2_exp[i]);
            idle(1'b1);
            idle(1'b0);
            check("t2 level", 32'(level), 32'd0);
        end
        check("t2 sticky", 32'(sticky_flags), 32'hF);

        // 3: fill to DEPTH, refused extra push, drain in order
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 32'h3F80_0000 + 32'(i), VALID, 1'b0, 1'b0);
        cyc(1'b1, 32'hDEAD_BEEF, VALID, 1'b0, 1'b0);
        check("t3 full in_ready", 32'(bus.in_ready), 32'd0);
        check("t3 full level", 32'(level), 32'(DEPTH));
        idle(1'b0);
        check("t3 no extra push", 32'(level), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) idle(1'b1);
        idle(1'b0);
        check("t3 drained level", 32'(level), 32'd0);
        check("t3 drained out_valid", 32'(bus.out_valid), 32'd0);

        // 4: steady push+pop at level 3 across pointer wrap
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'h4100_0000 + 32'(i), VALID, 1'b0, 1'b0);
        for (int i = 0; i < 2 * DEPTH; i++) begin
            cyc(1'b1, $urandom, VALID, 1'b1, 1'b0);
            check("t4 level", 32'(level), 32'd3);
        end
        for (int i = 0; i < 4; i++) idle(1'b1);
        idle(1'b0);
        check("t4 cnt saturated", 32'(result_cnt), 32'(CNT_MAX));

        // 5: clear coinciding with an infinity push, then clear alone
        check("t5 sticky before", 32'(sticky_flags), 32'hF);
        cyc(1'b1, 32'h1234_5678, positive_infinity, 1'b0, 1'b1);
        idle(1'b0);
        check("t5 clear+push", 32'(sticky_flags), 32'h1);
        cyc(1'b0, 32'h0, VALID, 1'b0, 1'b1);
        idle(1'b1);
        check("t5 clear only", 32'(sticky_flags), 32'h0);
        idle(1'b0);

        // Random traffic checked by the monitor
        for (int i = 0; i < 300; i++) begin
            cyc(($urandom_range(0, 9) < 7), $urandom, type_of_float'($urandom_range(0, 7)),
                ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0));
        end
        for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);
        idle(1'b0);

        // 6: asynchronous reset mid-stream
        for (int i = 0; i < 5; i++) cyc(1'b1, 32'h4000_0000 + 32'(i), NaN, 1'b0, 1'b0);
        idle(1'b0);
        check("t6 level before", 32'(level), 32'd5);
        #2 rst_n = 1'b0;
        #1;
        check("t6 reset level", 32'(level), 32'd0);
        check("t6 reset out_valid", 32'(bus.out_valid), 32'd0);
        check("t6 reset flags", 32'(sticky_flags), 32'd0);
        check("t6 reset cnt", 32'(result_cnt), 32'd0);
        #2 rst_n = 1'b1;
        #1;
        check("t6 release in_ready", 32'(bus.in_ready), 32'd1);
        idle(1'b0);
        check("t6 after release in_ready", 32'(bus.in_ready), 32'd1);
        check("t6 after release level", 32'(level), 32'd0);
        idle(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
